sprite_layer_mapper: RTL and testbench

SPRITE_LAYER_MAPPER -- requirements
Module: sprite_layer_mapper

---
 rtl/sprite_layer_mapper_pkg.sv | 31 +++
 rtl/sprite_layer_mapper_if.sv | 16 +
 rtl/sprite_layer_mapper_channel.sv | 67 ++++++
 rtl/sprite_layer_mapper.sv | 122 ++++++++++++
 tb/tb_sprite_layer_mapper.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_layer_mapper_pkg.sv
// Shared types, palette table and sizing constants for the sprite layer mapper.
package sprite_pkg;
    localparam int MAX_SPR     = 8;
    localparam int PAL_DEPTH   = 4;
    localparam int MAX_COORD_W = 16;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic [MAX_COORD_W-1:0] x;
        logic [MAX_COORD_W-1:0] y;
        logic                   vis;
        logic                   flip;
    } spr_reg_t;

    // Entry 0 of every row is never shown: texel index 0 means transparent.
    localparam rgb12_t SPR_PALETTE [MAX_SPR][PAL_DEPTH] = '{
        '{12'h000, 12'hD31, 12'hA50, 12'hD80},
        '{12'h000, 12'h3C3, 12'h0A5, 12'h5F0},
        '{12'h000, 12'h33D, 12'h50A, 12'h08D},
        '{12'h000, 12'hFF0, 12'h0FF, 12'hF0F},
        '{12'h000, 12'h888, 12'hCCC, 12'hFFF},
        '{12'h000, 12'h840, 12'hC60, 12'hFA0},
        '{12'h000, 12'h048, 12'h06C, 12'h0AF},
        '{12'h000, 12'h804, 12'hC06, 12'hF0A}
    };

    function automatic rgb12_t pal_color(input int ch, input int idx);
        return SPR_PALETTE[ch % MAX_SPR][idx % PAL_DEPTH];
    endfunction
endpackage

// File: rtl/sprite_layer_mapper_if.sv
// Sprite register write bus plus the frame_start strobe that commits shadow to active.
interface sprite_layer_mapper_if #(
    parameter int COORD_W = 10,
    parameter int IDX_W   = 2
);
    logic               spr_wr_en;
    logic [IDX_W-1:0]   spr_wr_idx;
    logic [COORD_W-1:0] spr_wr_x;
    logic [COORD_W-1:0] spr_wr_y;
    logic               spr_wr_vis;
    logic               spr_wr_flip;
    logic               frame_start;

    modport master (output spr_wr_en, spr_wr_idx, spr_wr_x, spr_wr_y, spr_wr_vis, spr_wr_flip, frame_start);
    modport slave  (input  spr_wr_en, spr_wr_idx, spr_wr_x, spr_wr_y, spr_wr_vis, spr_wr_flip, frame_start);
endinterface

// File: rtl/sprite_layer_mapper_channel.sv
// One sprite channel: shadow/active registers, bounding-box hit test, texel address.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int CH         = 0,
    parameter int SPR_DIM    = 16,
    parameter int SCALE_LOG2 = 1,
    parameter int COORD_W    = 10,
    parameter int IDX_W      = 2,
    localparam int AW        = $clog2(SPR_DIM)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    sprite_layer_mapper_if.slave wr_if,
    input  logic [COORD_W-1:0]   draw_x_i,
    input  logic [COORD_W-1:0]   draw_y_i,
    output logic                 hit_o,
    output logic [2*AW-1:0]      addr_o
);
    localparam int CW = MAX_COORD_W + 1;
    localparam logic [CW-1:0] SPAN_M1 = CW'((SPR_DIM << SCALE_LOG2) - 1);

    spr_reg_t shadow_q, shadow_d, active_q, active_d;
    logic     wr_sel;
    logic [CW-1:0] px, py, x0, y0;
    logic          hit_x, hit_y;
    logic [AW-1:0] col, row;

    assign wr_sel = wr_if.spr_wr_en && (wr_if.spr_wr_idx == IDX_W'(CH));

    // A write in the frame_start cycle lands in the copy to active.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_sel) begin
            shadow_d.x    = MAX_COORD_W'(wr_if.spr_wr_x);
            shadow_d.y    = MAX_COORD_W'(wr_if.spr_wr_y);
            shadow_d.vis  = wr_if.spr_wr_vis;
            shadow_d.flip = wr_if.spr_wr_flip;
        end
        active_d = wr_if.frame_start ? shadow_d : active_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // One extra bit of headroom keeps x+span from wrapping back onto column 0.
    always_comb begin
        px    = CW'(draw_x_i);
        py    = CW'(draw_y_i);
        x0    = CW'(active_q.x);
        y0    = CW'(active_q.y);
        hit_x = (px >= x0) && (px <= x0 + SPAN_M1);
        hit_y = (py >= y0) && (py <= y0 + SPAN_M1);
        col   = AW'((px - x0) >> SCALE_LOG2);
        row   = AW'((py - y0) >> SCALE_LOG2);
        if (active_q.flip) col = ~col;
        hit_o  = active_q.vis && hit_x && hit_y;
        addr_o = hit_o ? {row, col} : '0;
    end
endmodule

// File: rtl/sprite_layer_mapper.sv
// Sprite layer: per-channel hit/address, then ROM texel priority mux over background.
module sprite_layer_mapper
    import sprite_pkg::*;
#(
    parameter int NUM_SPR    = 4,
    parameter int SPR_DIM    = 16,
    parameter int SCALE_LOG2 = 1,
    parameter int PAL_W      = 2,
    parameter int COORD_W    = 10,
    localparam int IDX_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int AW        = $clog2(SPR_DIM)
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        pix_valid,
    input  logic [COORD_W-1:0]          DrawX,
    input  logic [COORD_W-1:0]          DrawY,
    input  logic                        frame_start,
    input  logic                        spr_wr_en,
    input  logic [IDX_W-1:0]            spr_wr_idx,
    input  logic [COORD_W-1:0]          spr_wr_x,
    input  logic [COORD_W-1:0]          spr_wr_y,
    input  logic                        spr_wr_vis,
    input  logic                        spr_wr_flip,
    output logic [NUM_SPR*2*AW-1:0]     rom_addr,
    input  logic [NUM_SPR*PAL_W-1:0]    rom_pal,
    input  logic [11:0]                 bg_rgb,
    output logic [3:0]                  Red,
    output logic [3:0]                  Green,
    output logic [3:0]                  Blue,
    output logic                        rgb_valid,
    output logic                        collision,
    output logic [NUM_SPR-1:0]          coll_mask
);
    localparam int STAGES = 3;

    sprite_layer_mapper_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) wr_bus ();
    assign wr_bus.spr_wr_en   = spr_wr_en;
    assign wr_bus.spr_wr_idx  = spr_wr_idx;
    assign wr_bus.spr_wr_x    = spr_wr_x;
    assign wr_bus.spr_wr_y    = spr_wr_y;
    assign wr_bus.spr_wr_vis  = spr_wr_vis;
    assign wr_bus.spr_wr_flip = spr_wr_flip;
    assign wr_bus.frame_start = frame_start;

    logic [NUM_SPR-1:0][2*AW-1:0]  addr_c, rom_addr_q;
    logic [NUM_SPR-1:0]            hit_c, hit1_q, hit2_q;
    logic [STAGES:1]               vld_pipe_q;
    logic [NUM_SPR-1:0][PAL_W-1:0] pal;
    logic [NUM_SPR-1:0]            opaque;
    rgb12_t                        pix_rgb, rgb_q, rgb_d;
    logic                          coll_q, coll_d;
    logic [NUM_SPR-1:0]            mask_q, mask_d;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_ch
        sprite_channel #(
            .CH(i), .SPR_DIM(SPR_DIM), .SCALE_LOG2(SCALE_LOG2),
            .COORD_W(COORD_W), .IDX_W(IDX_W)
        ) u_ch (
            .Clk      (Clk),
            .Reset_n  (Reset_n),
            .wr_if    (wr_bus.slave),
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .hit_o    (hit_c[i]),
            .addr_o   (addr_c[i])
        );
    end

    assign pal = rom_pal;

    // Walk from the top index down so the lowest opaque channel wins.
    always_comb begin
        opaque  = '0;
        pix_rgb = bg_rgb;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            opaque[i] = hit2_q[i] && (pal[i] != '0);
            if (opaque[i]) pix_rgb = pal_color(i, int'(pal[i]));
        end
    end

    // A collision in the frame_start cycle survives the clear.
    always_comb begin
        coll_d = coll_q;
        mask_d = mask_q;
        if (frame_start) begin
            coll_d = 1'b0;
            mask_d = '0;
        end
        if (vld_pipe_q[2] && ($countones(opaque) >= 2)) begin
            coll_d = 1'b1;
            mask_d = mask_d | opaque;
        end
        rgb_d = vld_pipe_q[2] ? pix_rgb : rgb_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            hit1_q     <= '0;
            hit2_q     <= '0;
            vld_pipe_q <= '0;
            rgb_q      <= '0;
            coll_q     <= 1'b0;
            mask_q     <= '0;
        end else begin
            rom_addr_q <= addr_c;
            hit1_q     <= hit_c;
            hit2_q     <= hit1_q;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], pix_valid};
            rgb_q      <= rgb_d;
            coll_q     <= coll_d;
            mask_q     <= mask_d;
        end
    end

    assign rom_addr           = rom_addr_q;
    assign {Red, Green, Blue} = rgb_q;
    assign rgb_valid          = vld_pipe_q[STAGES];
    assign collision          = coll_q;
    assign coll_mask          = mask_q;
endmodule

// File: tb/tb_sprite_layer_mapper.sv
// Scoreboard bench: random and directed pixels against a box-overlap reference model.
module tb_sprite_layer_mapper;
    import sprite_pkg::*;

    localparam int NUM_SPR = 4, SPR_DIM = 16, SCALE_LOG2 = 1, PAL_W = 2, COORD_W = 10;
    localparam int SPAN = SPR_DIM << SCALE_LOG2;

    logic        Clk = 1'b0, Reset_n = 1'b0, pix_valid = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic [31:0] rom_addr;
    logic [7:0]  rom_pal = '0;
    logic [11:0] bg_rgb = '0, bg_now = '0, bg_d1 = '0;
    logic [3:0]  Red, Green, Blue, coll_mask;
    logic        rgb_valid, collision;

    sprite_layer_mapper_if #(.COORD_W(COORD_W), .IDX_W(2)) wr_if ();

    sprite_layer_mapper #(
        .NUM_SPR(NUM_SPR), .SPR_DIM(SPR_DIM), .SCALE_LOG2(SCALE_LOG2),
        .PAL_W(PAL_W), .COORD_W(COORD_W)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(wr_if.frame_start), .spr_wr_en(wr_if.spr_wr_en), .spr_wr_idx(wr_if.spr_wr_idx),
        .spr_wr_x(wr_if.spr_wr_x), .spr_wr_y(wr_if.spr_wr_y), .spr_wr_vis(wr_if.spr_wr_vis),
        .spr_wr_flip(wr_if.spr_wr_flip), .rom_addr(rom_addr), .rom_pal(rom_pal), .bg_rgb(bg_rgb),
        .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid),
        .collision(collision), .coll_mask(coll_mask)
    );

    always #5 Clk = ~Clk;

    // Texture content: diagonal stripes, index 0 wherever (row+col+ch)%4==0.
    function automatic int tex(input int ch, input int row, input int col);
        return (row + col + ch) % 4;
    endfunction

    // Synchronous ROM and background source, both one cycle behind rom_addr.
    always @(posedge Clk) begin
        for (int i = 0; i < NUM_SPR; i++)
            rom_pal[i*PAL_W +: PAL_W] <= 2'(tex(i, int'(rom_addr[i*8+4 +: 4]), int'(rom_addr[i*8 +: 4])));
        bg_d1  <= bg_now;
        bg_rgb <= bg_d1;
    end

    typedef struct { int x; int y; bit vis; bit flip; } spr_m_t;
    typedef struct { bit v; logic [11:0] rgb; logic [3:0] opq; logic [31:0] addr; } item_t;
    typedef struct { logic [11:0] rgb; bit coll; logic [3:0] mask; logic [31:0] addr; } exp_t;

    spr_m_t      shadow_m [NUM_SPR];
    spr_m_t      active_m [NUM_SPR];
    item_t       pend [$];
    exp_t        exp_q [$];
    bit          coll_m = 1'b0;
    logic [3:0]  mask_m = '0;
    logic [11:0] exp_last = '0;
    logic [31:0] hist0 = '0, hist1 = '0;
    int          n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t predict(input bit pv, input int px, input int py, input logic [11:0] bg);
        item_t it;
        bit    found;
        int    col, row, t;
        it.v = pv; it.rgb = bg; it.opq = '0; it.addr = '0; found = 0;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (active_m[i].vis && px >= active_m[i].x && px < active_m[i].x + SPAN &&
                py >= active_m[i].y && py < active_m[i].y + SPAN) begin
                col = (px - active_m[i].x) / (1 << SCALE_LOG2);
                row = (py - active_m[i].y) / (1 << SCALE_LOG2);
                if (active_m[i].flip) col = SPR_DIM - 1 - col;
                it.addr[i*8 +: 8] = {4'(row), 4'(col)};
                t = tex(i, row, col);
                if (t != 0) begin
                    it.opq[i] = 1'b1;
                    if (!found) begin it.rgb = SPR_PALETTE[i][t]; found = 1; end
                end
            end
        end
        return it;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_SPR; i++) begin
            shadow_m[i] = '{0, 0, 1'b0, 1'b0};
            active_m[i] = '{0, 0, 1'b0, 1'b0};
        end
        pend.delete();
        exp_q.delete();
        pend.push_back('{1'b0, 12'h0, 4'h0, 32'h0});
        pend.push_back('{1'b0, 12'h0, 4'h0, 32'h0});
        coll_m = 1'b0; mask_m = '0; exp_last = '0;
    endtask

    // Drive one clock's worth of inputs and advance the reference model by one edge.
    task automatic step(input bit pv, input int px, input int py, input bit fs, input bit we,
                        input int widx, input int wx, input int wy, input bit wvis, input bit wflip);
        item_t       cur, done;
        exp_t        e;
        logic [11:0] bg;
        @(posedge Clk); #2;
        bg = 12'($urandom);
        pix_valid = pv; DrawX = 10'(px); DrawY = 10'(py); bg_now = bg;
        wr_if.frame_start = fs; wr_if.spr_wr_en = we; wr_if.spr_wr_idx = 2'(widx);
        wr_if.spr_wr_x = 10'(wx); wr_if.spr_wr_y = 10'(wy);
        wr_if.spr_wr_vis = wvis; wr_if.spr_wr_flip = wflip;
        cur  = predict(pv, px, py, bg);
        done = pend.pop_front();
        if (fs) begin coll_m = 1'b0; mask_m = '0; end
        if (done.v && $countones(done.opq) >= 2) begin coll_m = 1'b1; mask_m |= done.opq; end
        if (done.v) begin
            e.rgb = done.rgb; e.coll = coll_m; e.mask = mask_m; e.addr = done.addr;
            exp_q.push_back(e);
        end
        pend.push_back(cur);
        if (we) shadow_m[widx] = '{wx, wy, wvis, wflip};
        if (fs) active_m = shadow_m;
    endtask

    task automatic pix(input int px, input int py); step(1, px, py, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic fstart(); step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input int idx, input int x, input int y, input bit vis, input bit flip, input bit fs);
        step(0, 0, 0, fs, 1, idx, x, y, vis, flip);
    endtask
    task automatic chk_addr(input string name, input int ch, input logic [7:0] exp);
        #1 check(name, rom_addr[ch*8 +: 8], exp);
    endtask
    task automatic chk_rgb_after(input string name, input logic [11:0] exp);
        idle(); idle(); idle();
        #1 check(name, {Red, Green, Blue}, exp);
    endtask

    // Monitor: every valid output is popped from the scoreboard; idle cycles must hold RGB.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Reset_n) begin
                if (rgb_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rgb_valid", 64'(rgb_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("rgb", {Red, Green, Blue}, e.rgb);
                        check("collision", collision, e.coll);
                        check("coll_mask", coll_mask, e.mask);
                        check("rom_addr", hist1, e.addr);
                        exp_last = e.rgb;
                    end
                end else begin
                    check("rgb_hold", {Red, Green, Blue}, exp_last);
                end
            end
            hist1 = hist0;
            hist0 = rom_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, idx, x, y;
        bit fs;
        wr_if.frame_start = 0; wr_if.spr_wr_en = 0; wr_if.spr_wr_idx = '0;
        wr_if.spr_wr_x = '0; wr_if.spr_wr_y = '0; wr_if.spr_wr_vis = 0; wr_if.spr_wr_flip = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_rgb_valid", rgb_valid, 0);
        check("reset_rgb", {Red, Green, Blue}, 12'h000);
        check("reset_collision", collision, 0);
        check("reset_coll_mask", coll_mask, 4'h0);
        check("reset_rom_addr", rom_addr, 32'h0);
        #1 Reset_n = 1'b1;

        // Nothing visible out of reset; a write alone does not reach active.
        pix(100, 200); pix(110, 210);
        wr(0, 100, 200, 1, 0, 0);
        pix(102, 200); pix(120, 220);
        chk_rgb_after("shadow_only_bg", bg_now);

        fstart();
        pix(100, 200); idle(); chk_addr("addr_origin", 0, 8'h00);
        pix(131, 231); idle(); chk_addr("addr_corner", 0, 8'hFF);
        pix(132, 200); idle(); chk_addr("addr_past_edge", 0, 8'h00);
        pix(102, 200); chk_rgb_after("sprite0_colour", 12'hD31);

        wr(0, 400, 300, 1, 0, 1);
        pix(402, 300); chk_rgb_after("write_with_fstart", 12'hD31);

        wr(0, 300, 100, 1, 0, 0);
        wr(1, 300, 100, 1, 0, 1);
        pix(302, 100); chk_rgb_after("overlap_priority", 12'hD31);
        check("overlap_collision", collision, 1);
        check("overlap_mask", coll_mask, 4'b0011);
        fstart(); idle(); #1;
        check("fstart_clears_collision", collision, 0);
        check("fstart_clears_mask", coll_mask, 4'h0);

        wr(0, 100, 200, 1, 1, 1);
        pix(100, 200); idle(); chk_addr("flip_col", 0, 8'h0F);

        wr(2, 1020, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) pix(i, i);
        idle(); chk_addr("no_wrap", 2, 8'h00);
        pix(1021, 2); idle(); chk_addr("right_edge_hit", 2, 8'h10);

        // Random traffic with mid-line frame_starts and rewrites.
        for (int n = 0; n < 700; n++) begin
            r  = $urandom_range(0, 99);
            fs = ($urandom_range(0, 19) == 0);
            if (r < 15) begin
                idx = $urandom_range(0, NUM_SPR - 1);
                x = ($urandom_range(0, 9) == 0) ? $urandom_range(1000, 1023) : $urandom_range(180, 280);
                y = $urandom_range(180, 280);
                step(0, 0, 0, fs, 1, idx, x, y, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            end else begin
                x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : $urandom_range(170, 330);
                y = $urandom_range(170, 330);
                step(r < 90, 0 + x, y, fs, 0, 0, 0, 0, 0, 0);
            end
        end

        // Reset in the middle of a busy stream.
        wr(0, 300, 100, 1, 0, 1);
        pix(302, 100); pix(304, 100); pix(306, 100);
        @(posedge Clk); #2;
        Reset_n = 1'b0; pix_valid = 1'b0;
        #1;
        check("midreset_rgb_valid", rgb_valid, 0);
        check("midreset_rgb", {Red, Green, Blue}, 12'h000);
        check("midreset_collision", collision, 0);
        model_reset();
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
        pix(302, 100); pix(131, 231); pix(100, 200);
        chk_rgb_after("post_reset_bg", bg_now);
        fstart();
        pix(302, 100);

        repeat (4) idle();
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_collision", collision, coll_m);
        check("final_coll_mask", coll_mask, mask_m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
